// File: rtl/program_writer_pkg.sv
// Shared definitions for the program-memory image: opcodes, register count,
// default widths and the writer state encoding.
package program_writer_pkg;

   localparam int PW_ADDR_W   = 6;
   localparam int PW_DATA_W   = 4;
   localparam int PW_NUM_REGS = 8;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_MUL = 4'd2;
   localparam logic [3:0] OP_DIV = 4'd3;
   localparam logic [3:0] OP_END = 4'd4;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ACCEPT = 3'd1,
      S_W_OP   = 3'd2,
      S_W_RD   = 3'd3,
      S_W_RS1  = 3'd4,
      S_W_RS2  = 3'd5,
      S_W_END  = 3'd6,
      S_DONE   = 3'd7
   } pw_state_t;

   // Arithmetic opcode with every register index inside the register file.
   function automatic logic instr_legal(input logic [3:0] op,
                                        input logic [3:0] rd,
                                        input logic [3:0] rs1,
                                        input logic [3:0] rs2,
                                        input int         num_regs);
      instr_legal = (op <= OP_DIV) &&
                    (int'(rd) < num_regs) &&
                    (int'(rs1) < num_regs) &&
                    (int'(rs2) < num_regs);
   endfunction

endpackage

// File: rtl/program_writer.sv
// Serialises accepted instructions into four 4-bit memory words each and
// closes the program with an END word; all outputs are registered.
module program_writer
   import program_writer_pkg::*;
#(
   parameter int ADDR_W   = PW_ADDR_W,
   parameter int DATA_W   = PW_DATA_W,
   parameter int DEPTH    = 2 ** ADDR_W,
   parameter int NUM_REGS = PW_NUM_REGS
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [3:0]        instr_rd,
   input  logic [3:0]        instr_rs1,
   input  logic [3:0]        instr_rs2,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              error,
   output logic [4:0]        instr_count
);

   pw_state_t         r_state;
   logic [ADDR_W-1:0] r_base;
   logic [3:0]        r_rd;
   logic [3:0]        r_rs1;
   logic [3:0]        r_rs2;
   logic              r_ready;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_busy;
   logic              r_done;
   logic              r_overflow;
   logic              r_error;
   logic [4:0]        r_count;

   logic w_xfer;
   logic w_legal;
   logic w_room;

   assign w_xfer  = instr_valid && r_ready;
   assign w_legal = instr_legal(instr_op, instr_rd, instr_rs1, instr_rs2, NUM_REGS);
   // The last word of the instruction (base+3) must leave base+4 free for END.
   assign w_room  = (int'(r_base) + 4) <= (DEPTH - 1);

   // Writer FSM with pointer, field latches and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_rd        <= 4'd0;
         r_rs1       <= 4'd0;
         r_rs2       <= 4'd0;
         r_ready     <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_overflow  <= 1'b0;
         r_error     <= 1'b0;
         r_count     <= 5'd0;
      end else begin
         case (r_state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  r_state    <= S_ACCEPT;
                  r_base     <= '0;
                  r_count    <= 5'd0;
                  r_overflow <= 1'b0;
                  r_error    <= 1'b0;
                  r_ready    <= 1'b1;
                  r_busy     <= 1'b1;
                  r_done     <= 1'b0;
               end
            end
            S_ACCEPT: begin
               if (w_xfer) begin
                  r_rd  <= instr_rd;
                  r_rs1 <= instr_rs1;
                  r_rs2 <= instr_rs2;
                  if (instr_op == OP_END || (w_legal && !w_room)) begin
                     r_state     <= S_W_END;
                     r_ready     <= 1'b0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_base;
                     r_mem_wdata <= DATA_W'(OP_END);
                     r_overflow  <= r_overflow | (instr_op != OP_END);
                  end else if (w_legal) begin
                     r_state     <= S_W_OP;
                     r_ready     <= 1'b0;
                     r_mem_we    <= 1'b1;
                     r_mem_addr  <= r_base;
                     r_mem_wdata <= DATA_W'(instr_op);
                  end else begin
                     r_error <= 1'b1;
                  end
               end
            end
            S_W_OP: begin
               r_state     <= S_W_RD;
               r_mem_addr  <= r_base + ADDR_W'(1);
               r_mem_wdata <= DATA_W'(r_rd);
            end
            S_W_RD: begin
               r_state     <= S_W_RS1;
               r_mem_addr  <= r_base + ADDR_W'(2);
               r_mem_wdata <= DATA_W'(r_rs1);
            end
            S_W_RS1: begin
               r_state     <= S_W_RS2;
               r_mem_addr  <= r_base + ADDR_W'(3);
               r_mem_wdata <= DATA_W'(r_rs2);
            end
            S_W_RS2: begin
               r_state  <= S_ACCEPT;
               r_mem_we <= 1'b0;
               r_base   <= r_base + ADDR_W'(4);
               r_count  <= r_count + 5'd1;
               r_ready  <= 1'b1;
            end
            S_W_END: begin
               r_state  <= S_DONE;
               r_mem_we <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b1;
            end
            default: begin
               r_state  <= S_IDLE;
               r_ready  <= 1'b0;
               r_mem_we <= 1'b0;
               r_busy   <= 1'b0;
               r_done   <= 1'b0;
            end
         endcase
      end
   end

   assign instr_ready = r_ready;
   assign mem_we      = r_mem_we;
   assign mem_addr    = r_mem_addr;
   assign mem_wdata   = r_mem_wdata;
   assign busy        = r_busy;
   assign done        = r_done;
   assign overflow    = r_overflow;
   assign error       = r_error;
   assign instr_count = r_count;

endmodule

// File: tb/tb_program_writer.sv
// Randomised bench for program_writer: a transaction-level model predicts the
// memory writes (address, data, cycle) and a reader decodes the final image.
module tb_program_writer;
   import program_writer_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = 4'd0;
   logic [3:0] instr_rd = 4'd0;
   logic [3:0] instr_rs1 = 4'd0;
   logic [3:0] instr_rs2 = 4'd0;
   logic       mem_we;
   logic [5:0] mem_addr;
   logic [3:0] mem_wdata;
   logic       busy;
   logic       done;
   logic       overflow;
   logic       error;
   logic [4:0] instr_count;

   typedef struct { int addr; int data; int cyc; } wr_t;
   typedef struct { int op; int rd; int rs1; int rs2; } ins_t;

   wr_t  exp_q[$];
   ins_t prog[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   m_base, m_count, m_end_addr;
   bit   m_ovf, m_err, m_closed;
   logic [3:0] tb_mem [0:63];

   program_writer dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_rd(instr_rd),
      .instr_rs1(instr_rs1), .instr_rs2(instr_rs2),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .busy(busy), .done(done), .overflow(overflow), .error(error),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Every observed write must be the next one the model predicted.
   always @(negedge clk) begin
      if (rst_n && mem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {26'd0, mem_addr}, 32'hFFFF_FFFF);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            check("wr_addr", {26'd0, mem_addr}, e.addr);
            check("wr_data", {28'd0, mem_wdata}, e.data);
            check("wr_cycle", cyc, e.cyc);
         end
         tb_mem[mem_addr] = mem_wdata;
      end
   end

   task automatic model_clear();
      m_base = 0; m_count = 0; m_end_addr = -1;
      m_ovf = 0; m_err = 0; m_closed = 0;
      prog.delete();
      exp_q.delete();
   endtask

   task automatic push_end(input int n);
      exp_q.push_back('{m_base, 4, n + 1});
      m_end_addr = m_base;
      m_closed = 1;
   endtask

   task automatic model_xfer(input int op, input int rd, input int rs1, input int rs2, input int n);
      int f[4];
      f = '{op, rd, rs1, rs2};
      if (op == 4) begin
         push_end(n);
      end else if (op > 3 || rd >= 8 || rs1 >= 8 || rs2 >= 8) begin
         m_err = 1;
      end else if (m_base + 4 <= 63) begin
         for (int k = 0; k < 4; k++) exp_q.push_back('{m_base + k, f[k], n + 1 + k});
         prog.push_back('{op, rd, rs1, rs2});
         m_base += 4;
         m_count++;
      end else begin
         m_ovf = 1;
         push_end(n);
      end
   endtask

   // Offer one instruction, wait (bounded) for ready; n is the transfer cycle.
   task automatic send(input int op, input int rd, input int rs1, input int rs2,
                       input bit hold, output int n);
      bit got;
      got = 0;
      n = -1;
      @(negedge clk);
      instr_valid = 1'b1;
      instr_op = 4'(op); instr_rd = 4'(rd); instr_rs1 = 4'(rs1); instr_rs2 = 4'(rs2);
      for (int k = 0; k < 50; k++) begin
         if (instr_ready) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      if (!got) begin
         check("ready_timeout", 32'd0, 32'd1);
         instr_valid = 1'b0;
         return;
      end
      n = cyc;
      model_xfer(op, rd, rs1, rs2, n);
      @(posedge clk);
      #1;
      if (!hold) instr_valid = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_clear();
      check("start_ready", {31'd0, instr_ready}, 32'd1);
      check("start_busy", {31'd0, busy}, 32'd1);
      check("start_done", {31'd0, done}, 32'd0);
   endtask

   task automatic read_back();
      ins_t gp[$];
      int   a;
      bit   found;
      a = 0;
      found = 0;
      while (a < 64) begin
         if (tb_mem[a] === 4'd4) begin
            found = 1;
            break;
         end
         gp.push_back('{int'(tb_mem[a]), int'(tb_mem[a+1]), int'(tb_mem[a+2]), int'(tb_mem[a+3])});
         a += 4;
      end
      check("rd_end_found", {31'd0, found}, 32'd1);
      check("rd_end_addr", a, m_end_addr);
      check("rd_len", gp.size(), prog.size());
      for (int i = 0; i < gp.size() && i < prog.size(); i++) begin
         check("rd_op", gp[i].op, prog[i].op);
         check("rd_rd", gp[i].rd, prog[i].rd);
         check("rd_rs1", gp[i].rs1, prog[i].rs1);
         check("rd_rs2", gp[i].rs2, prog[i].rs2);
      end
   endtask

   task automatic finish_prog();
      int n;
      bit seen;
      if (!m_closed) send(4, $urandom_range(0, 15), 0, 0, 1'b0, n);
      instr_valid = 1'b0;
      seen = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (done) begin
            seen = 1;
            break;
         end
      end
      check("done_seen", {31'd0, seen}, 32'd1);
      check("end_busy", {31'd0, busy}, 32'd0);
      check("end_ready", {31'd0, instr_ready}, 32'd0);
      check("end_count", {27'd0, instr_count}, m_count);
      check("end_overflow", {31'd0, overflow}, {31'd0, m_ovf});
      check("end_error", {31'd0, error}, {31'd0, m_err});
      check("writes_pending", exp_q.size(), 0);
      read_back();
   endtask

   function automatic int rand_reg();
      return ($urandom_range(0, 15) == 0) ? int'($urandom_range(8, 15)) : int'($urandom_range(0, 7));
   endfunction

   function automatic int rand_op();
      int r;
      r = int'($urandom_range(0, 9));
      return (r < 8) ? (r % 4) : int'($urandom_range(5, 15));
   endfunction

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      model_clear();
      #12;
      check("rst_ready", {31'd0, instr_ready}, 32'd0);
      check("rst_we", {31'd0, mem_we}, 32'd0);
      check("rst_addr", {26'd0, mem_addr}, 32'd0);
      check("rst_data", {28'd0, mem_wdata}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_flags", {30'd0, overflow, error}, 32'd0);
      check("rst_count", {27'd0, instr_count}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // ADD R1,R2,R3 then END, with ready timing around the write burst.
      do_start();
      send(0, 1, 2, 3, 1'b0, n);
      while (cyc < n + 4) @(negedge clk);
      check("add_ready_n4", {31'd0, instr_ready}, 32'd0);
      @(negedge clk);
      check("add_ready_n5", {31'd0, instr_ready}, 32'd1);
      check("add_count", {27'd0, instr_count}, 32'd1);
      finish_prog();

      // Illegal opcode and out-of-range register are dropped, then MUL lands at base 0.
      do_start();
      send(7, 1, 1, 1, 1'b0, n);
      @(negedge clk);
      check("ill_error", {31'd0, error}, 32'd1);
      check("ill_ready", {31'd0, instr_ready}, 32'd1);
      send(1, 9, 0, 0, 1'b0, n);
      send(2, 4, 5, 6, 1'b0, n);
      finish_prog();

      // Sixteen legal instructions with valid held: the last one overflows.
      do_start();
      for (int i = 0; i < 16; i++)
         send(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
              int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, n);
      check("ovf_model_closed", {31'd0, m_closed}, 32'd1);
      finish_prog();
      check("ovf_end_at_60", m_end_addr, 60);

      // Reset during the rs1 write, then a fresh program from address 0.
      do_start();
      send(2, 4, 5, 6, 1'b0, n);
      while (cyc < n + 3) begin
         @(posedge clk);
         #1;
      end
      #1;
      check("mid_we_before", {31'd0, mem_we}, 32'd1);
      check("mid_addr_before", {26'd0, mem_addr}, 32'd2);
      rst_n = 1'b0;
      #1;
      check("mid_we_reset", {31'd0, mem_we}, 32'd0);
      check("mid_done_reset", {31'd0, done}, 32'd0);
      check("mid_busy_reset", {31'd0, busy}, 32'd0);
      check("mid_count_reset", {27'd0, instr_count}, 32'd0);
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      do_start();
      send(3, 7, 0, 1, 1'b0, n);
      finish_prog();

      // Random programs of varying length, including illegal entries.
      for (int p = 0; p < 6; p++) begin
         int len;
         do_start();
         len = int'($urandom_range(0, 18));
         for (int i = 0; i < len && !m_closed; i++)
            send(rand_op(), rand_reg(), rand_reg(), rand_reg(), 1'($urandom_range(0, 1)), n);
         finish_prog();
      end

      // A start while the program is open must be ignored.
      do_start();
      send(1, 2, 3, 4, 1'b0, n);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send(0, 5, 6, 7, 1'b0, n);
      finish_prog();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
